// File: rtl/usb_cdc_reg_bridge.sv
// Byte-oriented register bridge behind a USB CDC core: 'R' addr -> value, 'W' addr data -> 'K'.
// Seven read/write registers, a registered GPIO status at address 7, and a saturating error counter.
module usb_cdc_reg_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 48000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] out_data_i,
  input  logic       out_valid_i,
  output logic       out_ready_o,
  output logic [7:0] in_data_o,
  output logic       in_valid_o,
  input  logic       in_ready_i,
  output logic [7:0] ctrl_o,
  input  logic [7:0] gpio_i,
  output logic [7:0] err_cnt_o
);

  localparam logic [7:0]  OP_READ      = 8'h52;
  localparam logic [7:0]  OP_WRITE     = 8'h57;
  localparam logic [7:0]  RESP_OK      = 8'h4B;
  localparam logic [7:0]  RESP_ERR     = 8'h3F;
  localparam logic [7:0]  GPIO_ADDR    = 8'd7;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    RESP
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [7:0]  regs [0:6];
  logic        op_write;
  logic [7:0]  addr;
  logic [7:0]  resp_q;
  logic [7:0]  resp_d;
  logic [15:0] idle_cnt;
  logic [15:0] idle_cnt_d;
  logic [7:0]  gpio_q;
  logic [7:0]  err_cnt;
  logic [7:0]  rd_val;
  logic        accept;
  logic        xfer;
  logic        do_write;

  assign out_ready_o = (state != RESP) && !rst_i;
  assign accept      = out_valid_i && out_ready_o;
  assign in_valid_o  = (state == RESP);
  assign xfer        = in_valid_o && in_ready_i;
  assign in_data_o   = resp_q;
  assign ctrl_o      = regs[0];
  assign err_cnt_o   = err_cnt;

  // The incoming byte is the read address, so the lookup uses it directly.
  always_comb begin
    rd_val = RESP_ERR;
    case (out_data_i)
      8'd0:    rd_val = regs[0];
      8'd1:    rd_val = regs[1];
      8'd2:    rd_val = regs[2];
      8'd3:    rd_val = regs[3];
      8'd4:    rd_val = regs[4];
      8'd5:    rd_val = regs[5];
      8'd6:    rd_val = regs[6];
      8'd7:    rd_val = gpio_q;
      default: rd_val = RESP_ERR;
    endcase
  end

  always_comb begin
    state_d  = state;
    resp_d   = resp_q;
    do_write = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (out_data_i == OP_READ || out_data_i == OP_WRITE) begin
            state_d = GET_ADDR;
          end else begin
            state_d = RESP;
            resp_d  = RESP_ERR;
          end
        end
      end
      GET_ADDR: begin
        if (accept) begin
          if (op_write) begin
            state_d = GET_DATA;
          end else begin
            state_d = RESP;
            resp_d  = rd_val;
          end
        end else if (idle_cnt == TIMEOUT_LAST) begin
          state_d = IDLE;
        end
      end
      GET_DATA: begin
        if (accept) begin
          state_d = RESP;
          if (addr < GPIO_ADDR) begin
            do_write = 1'b1;
            resp_d   = RESP_OK;
          end else begin
            resp_d   = RESP_ERR;
          end
        end else if (idle_cnt == TIMEOUT_LAST) begin
          state_d = IDLE;
        end
      end
      RESP: begin
        if (xfer) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counts only while waiting inside a command; any accepted byte or state change restarts it.
  always_comb begin
    idle_cnt_d = 16'd0;
    if ((state == GET_ADDR || state == GET_DATA) && !accept && state_d == state) begin
      idle_cnt_d = idle_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      resp_q   <= 8'h00;
      idle_cnt <= 16'd0;
      op_write <= 1'b0;
      addr     <= 8'h00;
      gpio_q   <= 8'h00;
      err_cnt  <= 8'h00;
      for (int i = 0; i < 7; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      state    <= state_d;
      resp_q   <= resp_d;
      idle_cnt <= idle_cnt_d;
      gpio_q   <= gpio_i;
      if (state == IDLE && accept) begin
        op_write <= (out_data_i == OP_WRITE);
      end
      if (state == GET_ADDR && accept) begin
        addr <= out_data_i;
      end
      if (do_write) begin
        for (int i = 0; i < 7; i++) begin
          if (addr == 8'(i)) begin
            regs[i] <= out_data_i;
          end
        end
      end
      if (xfer && resp_q == RESP_ERR && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_usb_cdc_reg_bridge.sv
// Scoreboard bench for usb_cdc_reg_bridge: a command-level model pushes expected responses,
// a monitor pops them as the bridge hands bytes back to the host side.
module tb_usb_cdc_reg_bridge;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] out_data_i;
  logic       out_valid_i;
  logic       out_ready_o;
  logic [7:0] in_data_o;
  logic       in_valid_o;
  logic       in_ready_i;
  logic [7:0] ctrl_o;
  logic [7:0] gpio_i;
  logic [7:0] err_cnt_o;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q [$];
  logic [7:0] model_regs [0:6];
  logic [7:0] exp_err;
  int         bp_mode;
  bit         err_pending;
  bit         hold;
  logic [7:0] hold_data;

  usb_cdc_reg_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .out_data_i  (out_data_i),
    .out_valid_i (out_valid_i),
    .out_ready_o (out_ready_o),
    .in_data_o   (in_data_o),
    .in_valid_o  (in_valid_o),
    .in_ready_i  (in_ready_i),
    .ctrl_o      (ctrl_o),
    .gpio_i      (gpio_i),
    .err_cnt_o   (err_cnt_o)
  );

  initial forever #5 clk_i = ~clk_i;

  initial begin
    #800000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%02h required=0x%02h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=bound_expired required=event", name);
  endtask

  // Host-side backpressure: 0 always ready, 1 random, 2 held off.
  initial begin
    in_ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #2;
      case (bp_mode)
        0:       in_ready_i = 1'b1;
        1:       in_ready_i = 1'($urandom_range(0, 1));
        default: in_ready_i = 1'b0;
      endcase
    end
  end

  // Monitor: compares each transferred response against the scoreboard.
  initial begin
    forever begin
      @(negedge clk_i);
      if (err_pending) begin
        err_pending = 1'b0;
        check_output("err_cnt", err_cnt_o, exp_err);
      end
      if (!rst_i && in_valid_o) begin
        check_output("out_ready_in_resp", {7'b0, out_ready_o}, 8'h00);
        if (hold) check_output("resp_stable", in_data_o, hold_data);
        if (in_ready_i) begin
          hold = 1'b0;
          if (exp_q.size() == 0) begin
            check_output("unexpected_resp", in_data_o, 8'hxx);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check_output("resp_data", in_data_o, e);
            if (e == 8'h3F && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
          end
          err_pending = 1'b1;
        end else begin
          hold      = 1'b1;
          hold_data = in_data_o;
        end
      end else begin
        hold = 1'b0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic apply_stimulus(input logic [7:0] b, input bit fin);
    int n;
    n = 0;
    out_data_i  = b;
    out_valid_i = 1'b1;
    while (!out_ready_o && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 2000) begin
      fail_bound("accept_wait");
      out_valid_i = 1'b0;
      return;
    end
    @(negedge clk_i);
    out_valid_i = 1'b0;
    check_output("resp_latency", {7'b0, in_valid_o}, {7'b0, fin});
    check_output("ctrl", ctrl_o, model_regs[0]);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_valid_o) && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 3000) fail_bound("drain_wait");
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    out_valid_i = 1'b0;
    @(negedge clk_i);
    check_output("rst_out_ready", {7'b0, out_ready_o}, 8'h00);
    check_output("rst_in_valid", {7'b0, in_valid_o}, 8'h00);
    check_output("rst_in_data", in_data_o, 8'h00);
    check_output("rst_ctrl", ctrl_o, 8'h00);
    check_output("rst_err_cnt", err_cnt_o, 8'h00);
    for (int i = 0; i < 7; i++) model_regs[i] = 8'h00;
    exp_q.delete();
    exp_err     = 8'h00;
    err_pending = 1'b0;
    hold        = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check_output("post_rst_out_ready", {7'b0, out_ready_o}, 8'h01);
  endtask

  // Model: expected response for a read of the given address.
  function automatic logic [7:0] read_expect(input logic [7:0] a);
    if (a < 8'd7) return model_regs[a[2:0]];
    if (a == 8'd7) return gpio_i;
    return 8'h3F;
  endfunction

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int gap);
    apply_stimulus(8'h57, 1'b0);
    idle(gap);
    apply_stimulus(a, 1'b0);
    idle(gap);
    if (a < 8'd7) begin
      model_regs[a[2:0]] = d;
      exp_q.push_back(8'h4B);
    end else begin
      exp_q.push_back(8'h3F);
    end
    apply_stimulus(d, 1'b1);
  endtask

  task automatic do_read(input logic [7:0] a, input int gap);
    apply_stimulus(8'h52, 1'b0);
    idle(gap);
    exp_q.push_back(read_expect(a));
    apply_stimulus(a, 1'b1);
  endtask

  task automatic do_bad(input logic [7:0] b);
    exp_q.push_back(8'h3F);
    apply_stimulus(b, 1'b1);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] a;
    rst_i       = 1'b1;
    out_valid_i = 1'b0;
    out_data_i  = 8'h00;
    gpio_i      = 8'h00;
    bp_mode     = 0;
    exp_err     = 8'h00;
    err_pending = 1'b0;
    hold        = 1'b0;
    @(negedge clk_i);
    do_reset();

    // Basic write to the control register.
    do_write(8'h00, 8'hA5, 0);
    wait_drain();

    // Read held off by the host.
    do_write(8'h03, 8'h3C, 0);
    wait_drain();
    bp_mode = 2;
    idle(1);
    do_read(8'h03, 0);
    for (int i = 0; i < 5; i++) begin
      check_output("bp_valid", {7'b0, in_valid_o}, 8'h01);
      check_output("bp_data", in_data_o, 8'h3C);
      check_output("bp_out_ready", {7'b0, out_ready_o}, 8'h00);
      @(negedge clk_i);
    end
    bp_mode = 0;
    wait_drain();

    // GPIO status read.
    gpio_i = 8'h5A;
    idle(2);
    do_read(8'h07, 0);
    wait_drain();

    // Reset in the middle of a write.
    apply_stimulus(8'h57, 1'b0);
    apply_stimulus(8'h02, 1'b0);
    do_reset();
    idle(3);
    check_output("no_resp_after_rst", {7'b0, in_valid_o}, 8'h00);
    do_read(8'h02, 0);
    wait_drain();

    // Randomized command mix under random backpressure.
    bp_mode = 1;
    for (int k = 0; k < 150; k++) begin
      gpio_i = 8'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(7, 255)) : 8'($urandom_range(0, 6));
      case ($urandom_range(0, 4))
        0: begin
          do b = 8'($urandom); while (b == 8'h52 || b == 8'h57);
          do_bad(b);
        end
        1, 2: do_read(a, $urandom_range(0, 3));
        default: do_write(a, 8'($urandom), $urandom_range(0, 3));
      endcase
      idle($urandom_range(0, 2));
    end
    wait_drain();

    // Idle timeout abandons a partial write.
    bp_mode = 0;
    do_reset();
    apply_stimulus(8'h57, 1'b0);
    apply_stimulus(8'h01, 1'b0);
    idle(16);
    do_read(8'h01, 0);
    wait_drain();
    check_output("timeout_err_cnt", err_cnt_o, 8'h00);

    // Data byte arriving on the expiry cycle still completes the write.
    apply_stimulus(8'h57, 1'b0);
    apply_stimulus(8'h01, 1'b0);
    idle(15);
    model_regs[1] = 8'h77;
    exp_q.push_back(8'h4B);
    apply_stimulus(8'h77, 1'b1);
    wait_drain();
    do_read(8'h01, 0);
    wait_drain();

    // Error responses and counter saturation.
    do_reset();
    do_bad(8'h41);
    do_read(8'h09, 0);
    do_write(8'h07, 8'h11, 0);
    wait_drain();
    check_output("err_cnt_three", err_cnt_o, 8'h03);
    for (int i = 0; i < 7; i++) do_read(8'(i), 0);
    wait_drain();
    bp_mode = 1;
    for (int k = 0; k < 300; k++) begin
      do b = 8'($urandom); while (b == 8'h52 || b == 8'h57);
      do_bad(b);
    end
    wait_drain();
    check_output("err_cnt_sat", err_cnt_o, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
